div_arbiter: RTL

//   Shares one iterative fixed-point divider (start/done handshake) among NREQ requesters.

---
 rtl/div_arb_pkg.sv | 17 +
 rtl/div_arb_if.sv | 48 ++++
 rtl/rr_pick.sv | 40 ++++
 rtl/div_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared types and helpers for the divider arbiter.
// Optional watchdog build switch: DIV_ARB_TIMEOUT_EN.
package div_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Width of a requester index; never below one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/div_arb_if.sv
// div_arb_if: requester, response and divider-side signals of the arbiter.
// slave = arbiter side, master = clients plus divider side.
interface div_arb_if
    import div_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
);
    localparam int IDW = id_w(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_val;
    logic                  rsp_dbz;
    logic                  rsp_ovf;
    logic                  rsp_err;

    logic                  div_start;
    logic [WIDTH-1:0]      div_a;
    logic [WIDTH-1:0]      div_b;
    logic                  div_done;
    logic                  div_dbz;
    logic                  div_ovf;
    logic [WIDTH-1:0]      div_val;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        input  div_done, div_dbz, div_ovf, div_val,
        output req_ready, rsp_valid, rsp_id, rsp_val,
        output rsp_dbz, rsp_ovf, rsp_err,
        output div_start, div_a, div_b
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        output div_done, div_dbz, div_ovf, div_val,
        input  req_ready, rsp_valid, rsp_id, rsp_val,
        input  rsp_dbz, rsp_ovf, rsp_err,
        input  div_start, div_a, div_b
    );

endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin select.
// First set request at or after ptr (wrapping) wins.
module rr_pick
    import div_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0]   sum;
    logic [IW-1:0] k;

    // scan N slots starting at ptr, modulo N, keep the first hit
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        sum    = '0;
        k      = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            k = sum[IW-1:0];
            if (!any && req[k]) begin
                any       = 1'b1;
                idx       = k;
                onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin share of one iterative divider among NREQ clients.
// Build switch DIV_ARB_TIMEOUT_EN adds a WAIT watchdog that reports rsp_err.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input logic      clk,
    input logic      rst,
    div_arb_if.slave bus
);

    localparam int IDW = id_w(NREQ);

    if (NREQ < 2 || NREQ > 16 || TIMEOUT < 1) begin : g_param_chk
        $error("div_arbiter: NREQ must be 2..16, TIMEOUT >= 1");
    end

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [NREQ-1:0]  req_ready_q, req_ready_d;
    logic             div_start_q, div_start_d;
    logic [WIDTH-1:0] div_a_q, div_a_d;
    logic [WIDTH-1:0] div_b_q, div_b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_val_q, rsp_val_d;
    logic             rsp_dbz_q, rsp_dbz_d;
    logic             rsp_ovf_q, rsp_ovf_d;

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rsp_err_q, rsp_err_d;
`endif

    logic [NREQ-1:0]  pick_oh;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;

    rr_pick #(
        .N      (NREQ)
    ) u_pick (
        .req    (bus.req_valid),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // next-state and next-output computation for the grant/issue/wait/respond loop
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        req_ready_d = '0;
        div_start_d = 1'b0;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_val_d   = rsp_val_q;
        rsp_dbz_d   = rsp_dbz_q;
        rsp_ovf_d   = rsp_ovf_q;
`ifdef DIV_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    req_ready_d = pick_oh;
                    id_d        = pick_idx;
                    div_a_d     = bus.req_a[int'(pick_idx)*WIDTH +: WIDTH];
                    div_b_d     = bus.req_b[int'(pick_idx)*WIDTH +: WIDTH];
                    ptr_d       = (pick_idx == IDW'(NREQ - 1))
                                ? '0 : pick_idx + IDW'(1);
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                div_start_d = 1'b1;
`ifdef DIV_ARB_TIMEOUT_EN
                cnt_d       = '0;
`endif
                state_d     = WAIT;
            end
            WAIT: begin
                // a done while our own start pulse is still out is not ours
                if (bus.div_done && !div_start_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_val_d   = bus.div_val;
                    rsp_dbz_d   = bus.div_dbz;
                    rsp_ovf_d   = bus.div_ovf;
`ifdef DIV_ARB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = RESP;
`ifdef DIV_ARB_TIMEOUT_EN
                end else if (cnt_q >= CW'(TIMEOUT)) begin
                    rsp_valid_d = 1'b1;
                    rsp_val_d   = '0;
                    rsp_dbz_d   = 1'b0;
                    rsp_ovf_d   = 1'b0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d       = cnt_q + CW'(1);
`endif
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state, pointer and registered outputs; reset discards any in-flight op
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            req_ready_q <= '0;
            div_start_q <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_val_q   <= '0;
            rsp_dbz_q   <= 1'b0;
            rsp_ovf_q   <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            req_ready_q <= req_ready_d;
            div_start_q <= div_start_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_val_q   <= rsp_val_d;
            rsp_dbz_q   <= rsp_dbz_d;
            rsp_ovf_q   <= rsp_ovf_d;
`ifdef DIV_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.div_start = div_start_q;
    assign bus.div_a     = div_a_q;
    assign bus.div_b     = div_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_val   = rsp_val_q;
    assign bus.rsp_dbz   = rsp_dbz_q;
    assign bus.rsp_ovf   = rsp_ovf_q;
`ifdef DIV_ARB_TIMEOUT_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule
